// File: rtl/dp_sram_be.sv
// dp_sram_be: dual-port SRAM with byte enables, clear sequencer,
// selectable same-port read-during-write and optional output register.
module dp_sram_be #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned NB = DATA_WIDTH / 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  ready,
  input  logic                  en1,
  input  logic [NB-1:0]         wen1,
  input  logic [AW-1:0]         addr1,
  input  logic [DATA_WIDTH-1:0] data_in1,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic                  rvalid1,
  input  logic                  en2,
  input  logic [NB-1:0]         wen2,
  input  logic [AW-1:0]         addr2,
  input  logic [DATA_WIDTH-1:0] data_in2,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic                  rvalid2,
  output logic                  collision
);

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  in1, in2, acc1, acc2, we1, we2;
  logic                  same, coll;
  logic [DATA_WIDTH-1:0] old1, old2, new1, new2, rd1, rd2;

  // ready is held low for the transition cycle into READY and on clr
  assign ready_d = (state_q == S_READY) && !clr;

  // State, clear counter and ready register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Clear sequencing: walk the array, then open for accesses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_READY: begin
        if (clr) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign in1  = ({1'b0, addr1} < DEPTH_W);
  assign in2  = ({1'b0, addr2} < DEPTH_W);
  assign acc1 = ready_q & en1 & in1;
  assign acc2 = ready_q & en2 & in2;
  assign we1  = acc1 & (|wen1);
  assign we2  = acc2 & (|wen2);
  assign same = (addr1 == addr2);
  assign coll = acc1 & acc2 & same & (we1 | we2);
  assign old1 = in1 ? mem_q[addr1] : '0;
  assign old2 = in2 ? mem_q[addr2] : '0;

  // Final word at each port's address; port 1 owns shared bytes.
  always_comb begin
    new1 = old1;
    new2 = old2;
    for (int b = 0; b < NB; b++) begin
      if (we1 && wen1[b]) begin
        new1[8*b +: 8] = data_in1[8*b +: 8];
      end else if (we2 && same && wen2[b]) begin
        new1[8*b +: 8] = data_in2[8*b +: 8];
      end
      if (we1 && same && wen1[b]) begin
        new2[8*b +: 8] = data_in1[8*b +: 8];
      end else if (we2 && wen2[b]) begin
        new2[8*b +: 8] = data_in2[8*b +: 8];
      end
    end
  end

  assign rd1 = (RDW_MODE == 0 && we1) ? new1 : old1;
  assign rd2 = (RDW_MODE == 0 && we2) ? new2 : old2;

  // Array update: fill while clearing, port writes otherwise.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_INIT) begin
        mem_q[cnt_q] <= INIT_VALUE;
      end else begin
        if (we1) mem_q[addr1] <= new1;
        if (we2) mem_q[addr2] <= new2;
      end
    end
  end

  logic                  v1_q, v2_q, c_q;
  logic [DATA_WIDTH-1:0] d1_q, d2_q;

  // First output stage; data holds across idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      c_q  <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= acc1;
      v2_q <= acc2;
      c_q  <= coll;
      if (acc1) d1_q <= rd1;
      if (acc2) d2_q <= rd2;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  v1_p_q, v2_p_q, c_p_q;
      logic [DATA_WIDTH-1:0] d1_p_q, d2_p_q;

      // Second output stage keeps flags and data aligned.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v1_p_q <= 1'b0;
          v2_p_q <= 1'b0;
          c_p_q  <= 1'b0;
          d1_p_q <= '0;
          d2_p_q <= '0;
        end else begin
          v1_p_q <= v1_q;
          v2_p_q <= v2_q;
          c_p_q  <= c_q;
          if (v1_q) d1_p_q <= d1_q;
          if (v2_q) d2_p_q <= d2_q;
        end
      end

      assign rvalid1   = v1_p_q;
      assign rvalid2   = v2_p_q;
      assign collision = c_p_q;
      assign data_out1 = d1_p_q;
      assign data_out2 = d2_p_q;
    end else begin : g_direct
      assign rvalid1   = v1_q;
      assign rvalid2   = v2_q;
      assign collision = c_q;
      assign data_out1 = d1_q;
      assign data_out2 = d2_q;
    end
  endgenerate

  assign ready = ready_q;

endmodule

// File: doc/dp_sram_be.md
# dp_sram_be

Parametrised dual-port synchronous SRAM with per-byte write enables, selectable same-port read-during-write mode, and an optional output pipeline register. A built-in clear sequencer fills the array with a known value after reset or on request. It replaces the fixed-mode dual-port SRAM used by the branch-prediction tables and cache tag/data arrays in the renas CPU. It also flags same-address port collisions so that callers can detect lost or ambiguous accesses.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8
- DEPTH, 16, number of words; need not be a power of two
- RDW_MODE, 0, same-port read-during-write result: 0 = write-first (new data), 1 = read-first (old data)
- OUT_REG, 0, 1 adds one output register stage, making read latency 2
- INIT_VALUE, '0, DATA_WIDTH-wide fill value used by the clear sequencer
- Derived: NB = DATA_WIDTH/8; AW = $clog2(DEPTH), minimum 1

Ports (x = 1, 2):
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous and active-low
- clr  in  1  one-cycle request to restart the clear sequence
- ready  out  1  high when the array is initialised and accepting accesses
- enx  in  1  port x access enable
- wenx  in  NB  port x byte write enables; access is a write if any bit is set, otherwise a read
- addrx  in  AW  port x word address
- data_inx  in  DATA_WIDTH  port x write data
- data_outx  out  DATA_WIDTH  port x read data
- rvalidx  out  1  port x data_outx is valid this cycle
- collision  out  1  same-address conflict was detected on the access issued one cycle earlier

## Operation
- State machine has two states, INIT and READY.
- **Reset:** while rst_n = 0, state = INIT, clear counter = 0, and all outputs are driven to 0 (ready, rvalidx, data_outx, collision, pipeline registers).
- **INIT:**
  - Each cycle, write INIT_VALUE to the word at the clear counter, then increment the counter.
  - After the write to DEPTH-1, go to READY. ready rises on the next cycle.
  - Port inputs are ignored, and rvalidx stays 0.
- **READY:** both ports operate independently.
  - An access occurs when enx = 1 and addrx < DEPTH.
  - An out-of-range address is ignored: no write and no rvalid.
- **Write:** only bytes with wenx[b] = 1 are updated; all other bytes keep their old value.
- **Same-port read-during-write:** data_outx is driven with either
  - the merged new word (RDW_MODE = 0), or
  - the old word (RDW_MODE = 1).
  rvalidx is asserted for both reads and writes.
- **Cross-port, same address, one port writes:** the other port's read returns the old word. collision = 1.
- **Both ports write the same address:** merging is per byte.
  - Bytes enabled on port 1 take data_in1.
  - Bytes enabled only on port 2 take data_in2.
  - collision = 1.
- Both ports reading the same address is not a collision.
- **clr:** in READY, clr = 1 returns the block to INIT with counter = 0 on the next cycle. In INIT, clr restarts the counter at 0. An access presented in the same cycle as clr in READY is still performed.
- **rst_n = 0 mid-INIT or mid-access:** takes priority over everything. Pending pipeline data is discarded, and the sequence restarts from counter 0.

## Timing
- Read latency is 1 cycle after the enx cycle when OUT_REG = 0, and 2 cycles when OUT_REG = 1.
- rvalidx, data_outx and collision are aligned on the same output cycle.
- data_outx holds its last value when rvalidx = 0.
- Both ports can issue one access per cycle with no stalls.
- Clear duration:
  - After rst_n rises, ready first = 1 in cycle DEPTH + 1.
  - After clr is sampled in READY, ready = 0 from the next cycle and returns to 1 DEPTH + 1 cycles later.
- The earliest accepted access is in the first cycle with ready = 1.

## Test plan
- **Reset and clear:** DATA_WIDTH=32, DEPTH=16, INIT_VALUE=32'hA5A5A5A5. Release rst_n → ready = 1 exactly 17 cycles later, and reads of addresses 0..15 all return A5A5A5A5.
- **Byte writes:** port 1 writes addr 3 with wen1 = 4'b0101 and data_in1 = 32'h11223344 over the A5 fill → a port 2 read of addr 3 returns 32'hA522A544 one cycle later (two cycles with OUT_REG = 1).
- **RDW mode:** port 1 writes 32'hDEADBEEF to addr 5 (which holds 0), full mask.
  - RDW_MODE = 0 → data_out1 = DEADBEEF.
  - RDW_MODE = 1 → data_out1 = 0.
  - A later read in either mode returns DEADBEEF.
- **Dual-write collision:** port 1 writes 32'h000000FF with mask 0001, and port 2 writes 32'hFFFFFF00 with mask 1111, both to addr 7 in the same cycle → collision = 1 for one cycle, and addr 7 reads 32'hFFFFFFFF. Repeating with port 1 mask 1111 → addr 7 reads 32'h000000FF.
- **Cross-port read and out-of-range:** port 1 writes addr 2 while port 2 reads addr 2 → port 2 gets the old word, collision = 1. With DEPTH = 12, an access to addr 13 → no write and rvalid = 0.
- **clr and reset mid-operation:** assert clr in READY while port 1 writes addr 0 → ready drops next cycle and addr 0 ends at INIT_VALUE. Assert rst_n = 0 at counter = 8 → counter restarts at 0, and ready returns 17 cycles after release.
